// File: rtl/alarm_pkg.sv
// Shared alarm state codes, also decoded by the LCD/SEG display logic.
package alarm_pkg;

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    ARMED    = 3'd1,
    ENTRY    = 3'd2,
    ALARM    = 3'd3,
    SILENCED = 3'd4
  } state_e;

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter shared by the entry delay and the siren duration.
module alarm_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk_2,
  input  logic         reset_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/zone_alarm_ctrl.sv
// Multi-zone intrusion alarm: delayed entry zone 0, timed siren, latched cause mask.
// Optional first-zone capture register enabled by ZONE_ALARM_FIRST_ZONE_EN.
module zone_alarm_ctrl #(
  parameter int unsigned NZONES     = 4,
  parameter int unsigned ENTRY_DLY  = 5,
  parameter int unsigned SIREN_TIME = 8
) (
  input  logic                      clk_2,
  input  logic                      reset_n,
  input  logic                      arm,
  input  logic                      disarm,
  input  logic [NZONES-1:0]         zone_open,
  input  logic [NZONES-1:0]         bypass,
  output logic                      armed,
  output logic                      entry_warn,
  output logic                      siren,
  output logic                      arm_fail,
  output logic [NZONES-1:0]         cause,
  output logic [$clog2(NZONES)-1:0] first_zone,
  output logic [2:0]                state_o
);

  import alarm_pkg::*;

  localparam int unsigned T_MAX = (ENTRY_DLY > SIREN_TIME) ? ENTRY_DLY : SIREN_TIME;
  localparam int unsigned CNT_W = $clog2(T_MAX + 1);
  // Timer is loaded with N-1 so the zero flag marks the last cycle of an N-cycle interval.
  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_DLY - 1);
  localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_TIME - 1);

  state_e            state_q, state_d;
  logic [NZONES-1:0] act;
  logic              hi_act;
  logic [NZONES-1:0] cause_d;
  logic              arm_fail_d;
  logic              t_load, t_en, t_zero;
  logic [CNT_W-1:0]  t_val;

  assign act    = zone_open & ~bypass;
  assign hi_act = |act[NZONES-1:1];

  alarm_timer #(.W(CNT_W)) u_timer (
    .clk_2   (clk_2),
    .reset_n (reset_n),
    .load    (t_load),
    .en      (t_en),
    .val     (t_val),
    .zero    (t_zero)
  );

  always_comb begin
    state_d    = state_q;
    cause_d    = cause;
    arm_fail_d = 1'b0;
    t_load     = 1'b0;
    t_en       = 1'b0;
    t_val      = '0;
    if (state_q inside {ENTRY, ALARM, SILENCED}) cause_d = cause | act;
    if (disarm) begin
      state_d = DISARMED;
    end else begin
      case (state_q)
        DISARMED: begin
          if (arm) begin
            if (act == '0) begin
              state_d = ARMED;
              cause_d = '0;
            end else begin
              arm_fail_d = 1'b1;
            end
          end
        end
        ARMED: begin
          if (hi_act) begin
            state_d = ALARM;
            t_load  = 1'b1;
            t_val   = SIREN_LD;
            cause_d = cause | act;
          end else if (act[0]) begin
            state_d = ENTRY;
            t_load  = 1'b1;
            t_val   = ENTRY_LD;
            cause_d = cause | act;
          end
        end
        ENTRY: begin
          if (hi_act || t_zero) begin
            state_d = ALARM;
            t_load  = 1'b1;
            t_val   = SIREN_LD;
          end else begin
            t_en = 1'b1;
          end
        end
        ALARM: begin
          if (t_zero) state_d = SILENCED;
          else        t_en    = 1'b1;
        end
        SILENCED: begin
          if (|(act & ~cause)) begin
            state_d = ALARM;
            t_load  = 1'b1;
            t_val   = SIREN_LD;
          end
        end
        default: state_d = DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= DISARMED;
      armed      <= 1'b0;
      entry_warn <= 1'b0;
      siren      <= 1'b0;
      arm_fail   <= 1'b0;
      cause      <= '0;
    end else begin
      state_q    <= state_d;
      armed      <= (state_d != DISARMED);
      entry_warn <= (state_d == ENTRY);
      siren      <= (state_d == ALARM);
      arm_fail   <= arm_fail_d;
      cause      <= cause_d;
    end
  end

  assign state_o = state_q;

`ifdef ZONE_ALARM_FIRST_ZONE_EN
  localparam int unsigned FZ_W = $clog2(NZONES);

  logic [FZ_W-1:0] low_idx;

  always_comb begin
    low_idx = '0;
    for (int unsigned i = NZONES; i > 0; i--) begin
      if (act[i-1]) low_idx = FZ_W'(i - 1);
    end
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      first_zone <= '0;
    end else if (state_q == DISARMED && state_d == ARMED) begin
      first_zone <= '0;
    end else if ((state_q == ARMED || state_q == ENTRY) && state_d == ALARM) begin
      first_zone <= low_idx;
    end
  end
`else
  assign first_zone = '0;
`endif

endmodule

// File: tb/tb_zone_alarm_ctrl.sv
// Bench for zone_alarm_ctrl: directed scenarios plus randomized traffic against a mode/countdown model.
module tb_zone_alarm_ctrl;

  localparam int NZ    = 4;
  localparam int EDLY  = 5;
  localparam int STIME = 8;

  logic          clk_2 = 1'b0;
  logic          reset_n = 1'b0;
  logic          arm = 1'b0;
  logic          disarm = 1'b0;
  logic [NZ-1:0] zone_open = '0;
  logic [NZ-1:0] bypass = '0;
  logic          armed, entry_warn, siren, arm_fail;
  logic [NZ-1:0] cause;
  logic [1:0]    first_zone;
  logic [2:0]    state_o;

  int total = 0;
  int bad   = 0;
  logic run = 1'b0;

  zone_alarm_ctrl #(.NZONES(NZ), .ENTRY_DLY(EDLY), .SIREN_TIME(STIME)) dut (
    .clk_2      (clk_2),
    .reset_n    (reset_n),
    .arm        (arm),
    .disarm     (disarm),
    .zone_open  (zone_open),
    .bypass     (bypass),
    .armed      (armed),
    .entry_warn (entry_warn),
    .siren      (siren),
    .arm_fail   (arm_fail),
    .cause      (cause),
    .first_zone (first_zone),
    .state_o    (state_o)
  );

  always #5 clk_2 = ~clk_2;

  // Model: armed flag, remaining entry cycles, remaining siren cycles, silenced flag.
  logic          m_on, m_sil, m_fail;
  int            m_entry, m_siren;
  logic [NZ-1:0] m_cause;
  int            m_fz;
  logic          n_on, n_sil, n_fail;
  int            n_entry, n_siren;
  logic [NZ-1:0] n_cause;
  int            n_fz;
  logic [NZ-1:0] m_act;

  function automatic int lowest(input logic [NZ-1:0] v);
    for (int i = 0; i < NZ; i++) if (v[i]) return i;
    return 0;
  endfunction

  always_comb begin
    m_act   = zone_open & ~bypass;
    n_on    = m_on;
    n_sil   = m_sil;
    n_entry = m_entry;
    n_siren = m_siren;
    n_cause = m_cause;
    n_fz    = m_fz;
    n_fail  = !m_on && arm && !disarm && (m_act != 0);
    if (m_on && (m_entry > 0 || m_siren > 0 || m_sil)) n_cause = m_cause | m_act;
    if (disarm) begin
      n_on = 0; n_entry = 0; n_siren = 0; n_sil = 0;
    end else if (!m_on) begin
      if (arm && m_act == 0) begin n_on = 1; n_cause = 0; n_fz = 0; end
    end else if (m_entry > 0) begin
      if (m_act[3:1] != 0) begin n_entry = 0; n_siren = STIME; n_fz = lowest(m_act); end
      else if (m_entry == 1) begin n_entry = 0; n_siren = STIME; n_fz = 0; end
      else n_entry = m_entry - 1;
    end else if (m_siren > 0) begin
      n_siren = m_siren - 1;
      if (m_siren == 1) n_sil = 1;
    end else if (m_sil) begin
      if ((m_act & ~m_cause) != 0) begin n_sil = 0; n_siren = STIME; end
    end else begin
      if (m_act[3:1] != 0) begin n_siren = STIME; n_cause = m_cause | m_act; n_fz = lowest(m_act); end
      else if (m_act[0]) begin n_entry = EDLY; n_cause = m_cause | m_act; end
    end
  end

  always @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      m_on <= 0; m_sil <= 0; m_fail <= 0; m_entry <= 0; m_siren <= 0; m_cause <= '0; m_fz <= 0;
    end else begin
      m_on <= n_on; m_sil <= n_sil; m_fail <= n_fail; m_entry <= n_entry;
      m_siren <= n_siren; m_cause <= n_cause; m_fz <= n_fz;
    end
  end

  function automatic int exp_state();
    if (!m_on) return 0;
    if (m_entry > 0) return 2;
    if (m_siren > 0) return 3;
    if (m_sil) return 4;
    return 1;
  endfunction

  function automatic int exp_fz();
`ifdef ZONE_ALARM_FIRST_ZONE_EN
    return m_fz;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk_2) begin
    if (run) begin
      check("m_state", int'(state_o), exp_state());
      check("m_armed", int'(armed), int'(m_on));
      check("m_entry_warn", int'(entry_warn), int'(m_entry > 0));
      check("m_siren", int'(siren), int'(m_siren > 0));
      check("m_arm_fail", int'(arm_fail), int'(m_fail));
      check("m_cause", int'(cause), int'(m_cause));
      check("m_first_zone", int'(first_zone), exp_fz());
    end
  end

  task automatic tick();
    @(posedge clk_2);
    #2;
  endtask

  task automatic idle_inputs();
    arm = 0; disarm = 0; zone_open = '0; bypass = '0;
  endtask

  int fz_t5;

  initial begin
`ifdef ZONE_ALARM_FIRST_ZONE_EN
    fz_t5 = 1;
`else
    fz_t5 = 0;
`endif
    idle_inputs();
    reset_n = 0;
    repeat (2) tick();
    check("rst_state", int'(state_o), 0);
    check("rst_cause", int'(cause), 0);
    check("rst_armed", int'(armed), 0);
    reset_n = 1;
    run = 1;

    // 1: arm refused with zone 1 open
    arm = 1; zone_open = 4'b0010; tick();
    check("t1_arm_fail", int'(arm_fail), 1);
    check("t1_state", int'(state_o), 0);
    check("t1_armed", int'(armed), 0);
    idle_inputs(); tick();
    check("t1_fail_drop", int'(arm_fail), 0);

    // 2: entry then disarm at cycle 3
    arm = 1; tick();
    check("t2_armed", int'(state_o), 1);
    arm = 0; zone_open = 4'b0001; tick();
    check("t2_entry", int'(state_o), 2);
    check("t2_warn", int'(entry_warn), 1);
    zone_open = '0; tick(); tick();
    disarm = 1; tick();
    check("t2_disarmed", int'(state_o), 0);
    check("t2_siren", int'(siren), 0);
    check("t2_cause", int'(cause), 1);
    disarm = 0;

    // 3: entry timeout, siren for 8 cycles, silenced
    arm = 1; tick();
    arm = 0; zone_open = 4'b0001; tick();
    for (int i = 1; i <= EDLY; i++) begin
      tick();
      check("t3_entry_siren", int'(siren), int'(i == EDLY));
    end
    for (int j = 1; j <= STIME; j++) begin
      tick();
      check("t3_siren", int'(siren), int'(j < STIME));
    end
    check("t3_silenced", int'(state_o), 4);
    check("t3_cause", int'(cause), 1);

    // 4: new zone retriggers from SILENCED
    zone_open = 4'b0100; tick();
    check("t4_alarm", int'(state_o), 3);
    check("t4_cause", int'(cause), 5);
    check("t4_fz", int'(first_zone), 0);
    for (int j = 1; j <= STIME; j++) begin
      tick();
      check("t4_siren", int'(siren), int'(j < STIME));
    end
    check("t4_silenced", int'(state_o), 4);
    disarm = 1; zone_open = '0; tick();
    check("t4_keep_cause", int'(cause), 5);
    disarm = 0;

    // 5: bypassed zone ignored for arming, zone 1 trips
    bypass = 4'b1000; zone_open = 4'b1000; arm = 1; tick();
    check("t5_armed", int'(state_o), 1);
    check("t5_no_fail", int'(arm_fail), 0);
    arm = 0; zone_open = 4'b1010; tick();
    check("t5_alarm", int'(state_o), 3);
    check("t5_cause", int'(cause), 2);
    check("t5_fz", int'(first_zone), fz_t5);

    // 6: arm+disarm together, then async reset during ALARM
    idle_inputs(); arm = 1; disarm = 1; tick();
    check("t6_disarm_wins", int'(state_o), 0);
    disarm = 0; tick();
    arm = 0; zone_open = 4'b0100; tick();
    tick();
    check("t6_siren_on", int'(siren), 1);
    reset_n = 0; #1;
    check("t6_rst_siren", int'(siren), 0);
    check("t6_rst_state", int'(state_o), 0);
    check("t6_rst_cause", int'(cause), 0);
    check("t6_rst_armed", int'(armed), 0);
    idle_inputs(); tick();
    reset_n = 1;

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      arm    = ($urandom % 5) == 0;
      disarm = ($urandom % 25) == 0;
      if (($urandom % 3) == 0) begin
        for (int b = 0; b < NZ; b++) zone_open[b] = ($urandom % 9) == 0;
      end
      if (($urandom % 60) == 0) bypass = NZ'($urandom);
      if (($urandom % 500) == 0) begin
        reset_n = 0; tick(); reset_n = 1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
